id_ex_fwd_stage: RTL and testbench

//   ID/EX pipeline register of the ARM pipeline, with freeze (hold) and flush (bubble) control.

---
 rtl/id_ex_fwd_stage_if.sv | 68 ++++++
 rtl/id_ex_fwd_stage.sv | 124 ++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_fwd_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_fwd_stage_if
// Brief    : ID/EX stage bus - decoded ID fields in, registered EX fields and
//            forwarding selects out, plus stage control and MEM/WB producer info.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_fwd_stage_if #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 4
);
    logic                freeze;
    logic                flush;
    logic                fwd_en;

    logic                id_valid;
    logic [WIDTH-1:0]    id_val_rn;
    logic [WIDTH-1:0]    id_val_rm;
    logic [REG_ADDR-1:0] id_src1;
    logic [REG_ADDR-1:0] id_src2;
    logic                id_two_src;
    logic [REG_ADDR-1:0] id_dest;
    logic                id_wb_en;
    logic                id_mem_r_en;
    logic                id_mem_w_en;
    logic [3:0]          id_exe_cmd;

    logic [REG_ADDR-1:0] mem_dest;
    logic                mem_wb_en;
    logic [REG_ADDR-1:0] wb_dest;
    logic                wb_wb_en;

    logic                ex_valid;
    logic [WIDTH-1:0]    ex_val_rn;
    logic [WIDTH-1:0]    ex_val_rm;
    logic [REG_ADDR-1:0] ex_src1;
    logic [REG_ADDR-1:0] ex_src2;
    logic                ex_two_src;
    logic [REG_ADDR-1:0] ex_dest;
    logic                ex_wb_en;
    logic                ex_mem_r_en;
    logic                ex_mem_w_en;
    logic [3:0]          ex_exe_cmd;

    logic [1:0]          sel_src1;
    logic [1:0]          sel_src2;

    modport master (
        output freeze, flush, fwd_en,
        output id_valid, id_val_rn, id_val_rm, id_src1, id_src2, id_two_src,
        output id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
        output mem_dest, mem_wb_en, wb_dest, wb_wb_en,
        input  ex_valid, ex_val_rn, ex_val_rm, ex_src1, ex_src2, ex_two_src,
        input  ex_dest, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_exe_cmd,
        input  sel_src1, sel_src2
    );

    modport slave (
        input  freeze, flush, fwd_en,
        input  id_valid, id_val_rn, id_val_rm, id_src1, id_src2, id_two_src,
        input  id_dest, id_wb_en, id_mem_r_en, id_mem_w_en, id_exe_cmd,
        input  mem_dest, mem_wb_en, wb_dest, wb_wb_en,
        output ex_valid, ex_val_rn, ex_val_rm, ex_src1, ex_src2, ex_two_src,
        output ex_dest, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_exe_cmd,
        output sel_src1, sel_src2
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_fwd_stage
// Brief    : ID/EX pipeline register with freeze/flush, EX operand-forwarding
//            select generation and a saturating forwarded-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_fwd_stage #(
    parameter int WIDTH    = 32,
    parameter int REG_ADDR = 4,
    parameter int CNT_W    = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    id_ex_fwd_stage_if.slave      bus,
    output logic [CNT_W-1:0]      fwd_count
);
    localparam logic [1:0]       c_SEL_RF  = 2'b00;
    localparam logic [1:0]       c_SEL_MEM = 2'b01;
    localparam logic [1:0]       c_SEL_WB  = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic                r_valid;
    logic [WIDTH-1:0]    r_val_rn;
    logic [WIDTH-1:0]    r_val_rm;
    logic [REG_ADDR-1:0] r_src1;
    logic [REG_ADDR-1:0] r_src2;
    logic                r_two_src;
    logic [REG_ADDR-1:0] r_dest;
    logic                r_wb_en;
    logic                r_mem_r_en;
    logic                r_mem_w_en;
    logic [3:0]          r_exe_cmd;
    logic [CNT_W-1:0]    r_fwd_count;

    logic [1:0]          w_sel1;
    logic [1:0]          w_sel2;
    logic                w_fwd_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_two_src  <= 1'b0;
            r_dest     <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_exe_cmd  <= '0;
        end else if (bus.flush) begin
            r_valid    <= 1'b0;
            r_val_rn   <= '0;
            r_val_rm   <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_two_src  <= 1'b0;
            r_dest     <= '0;
            r_wb_en    <= 1'b0;
            r_mem_r_en <= 1'b0;
            r_mem_w_en <= 1'b0;
            r_exe_cmd  <= '0;
        end else if (!bus.freeze) begin
            r_valid    <= bus.id_valid;
            r_val_rn   <= bus.id_val_rn;
            r_val_rm   <= bus.id_val_rm;
            r_src1     <= bus.id_src1;
            r_src2     <= bus.id_src2;
            r_two_src  <= bus.id_two_src;
            r_dest     <= bus.id_dest;
            r_wb_en    <= bus.id_wb_en;
            r_mem_r_en <= bus.id_mem_r_en;
            r_mem_w_en <= bus.id_mem_w_en;
            r_exe_cmd  <= bus.id_exe_cmd;
        end
    end

    // MEM is checked before WB so the youngest producer wins.
    always_comb begin
        w_sel1 = c_SEL_RF;
        w_sel2 = c_SEL_RF;
        if (bus.fwd_en && r_valid) begin
            if (bus.mem_wb_en && (bus.mem_dest == r_src1))
                w_sel1 = c_SEL_MEM;
            else if (bus.wb_wb_en && (bus.wb_dest == r_src1))
                w_sel1 = c_SEL_WB;

            if (r_two_src) begin
                if (bus.mem_wb_en && (bus.mem_dest == r_src2))
                    w_sel2 = c_SEL_MEM;
                else if (bus.wb_wb_en && (bus.wb_dest == r_src2))
                    w_sel2 = c_SEL_WB;
            end
        end
    end

    // Counting only on non-frozen edges makes a stalled instruction count once.
    assign w_fwd_evt = r_valid && !bus.freeze && ((w_sel1 != c_SEL_RF) || (w_sel2 != c_SEL_RF));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_fwd_count <= '0;
        else if (w_fwd_evt && (r_fwd_count != {CNT_W{1'b1}}))
            r_fwd_count <= r_fwd_count + c_CNT_ONE;
    end

    assign bus.ex_valid    = r_valid;
    assign bus.ex_val_rn   = r_val_rn;
    assign bus.ex_val_rm   = r_val_rm;
    assign bus.ex_src1     = r_src1;
    assign bus.ex_src2     = r_src2;
    assign bus.ex_two_src  = r_two_src;
    assign bus.ex_dest     = r_dest;
    assign bus.ex_wb_en    = r_wb_en;
    assign bus.ex_mem_r_en = r_mem_r_en;
    assign bus.ex_mem_w_en = r_mem_w_en;
    assign bus.ex_exe_cmd  = r_exe_cmd;
    assign bus.sel_src1    = w_sel1;
    assign bus.sel_src2    = w_sel2;
    assign fwd_count       = r_fwd_count;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_fwd_stage
// Brief    : Directed self-checking bench for id_ex_fwd_stage; a second,
//            narrow-counter instance shares the stimulus to reach saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_fwd_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] fwd_count;
    logic [2:0]  small_count;
    int          checks = 0;
    int          errors = 0;

    id_ex_fwd_stage_if #(.WIDTH(32), .REG_ADDR(4)) b ();
    id_ex_fwd_stage_if #(.WIDTH(32), .REG_ADDR(4)) bs ();

    id_ex_fwd_stage #(.WIDTH(32), .REG_ADDR(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(b), .fwd_count(fwd_count)
    );
    id_ex_fwd_stage #(.WIDTH(32), .REG_ADDR(4), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .bus(bs), .fwd_count(small_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        bs.freeze      = b.freeze;
        bs.flush       = b.flush;
        bs.fwd_en      = b.fwd_en;
        bs.id_valid    = b.id_valid;
        bs.id_val_rn   = b.id_val_rn;
        bs.id_val_rm   = b.id_val_rm;
        bs.id_src1     = b.id_src1;
        bs.id_src2     = b.id_src2;
        bs.id_two_src  = b.id_two_src;
        bs.id_dest     = b.id_dest;
        bs.id_wb_en    = b.id_wb_en;
        bs.id_mem_r_en = b.id_mem_r_en;
        bs.id_mem_w_en = b.id_mem_w_en;
        bs.id_exe_cmd  = b.id_exe_cmd;
        bs.mem_dest    = b.mem_dest;
        bs.mem_wb_en   = b.mem_wb_en;
        bs.wb_dest     = b.wb_dest;
        bs.wb_wb_en    = b.wb_wb_en;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        b.freeze = 0; b.flush = 0; b.fwd_en = 1;
        b.id_valid = 0; b.id_val_rn = '0; b.id_val_rm = '0;
        b.id_src1 = '0; b.id_src2 = '0; b.id_two_src = 0; b.id_dest = '0;
        b.id_wb_en = 0; b.id_mem_r_en = 0; b.id_mem_w_en = 0; b.id_exe_cmd = '0;
        b.mem_dest = '0; b.mem_wb_en = 0; b.wb_dest = '0; b.wb_wb_en = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            b.freeze = 1'($urandom); b.flush = 1'($urandom); b.fwd_en = 1;
            b.id_valid = 1; b.id_val_rn = $urandom; b.id_val_rm = $urandom;
            b.id_src1 = 4'($urandom); b.id_src2 = 4'($urandom); b.id_two_src = 1;
            b.id_dest = 4'($urandom); b.id_wb_en = 1; b.id_mem_r_en = 1;
            b.id_mem_w_en = 1; b.id_exe_cmd = 4'($urandom);
            b.mem_dest = b.id_src1; b.mem_wb_en = 1; b.wb_dest = b.id_src2; b.wb_wb_en = 1;
            tick();
        end
        checks++; if (b.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %0b want 0", b.ex_valid); end
        checks++; if (b.ex_val_rn !== 32'h0) begin errors++; $display("FAIL reset_ex_val_rn: got %h want 0", b.ex_val_rn); end
        checks++; if (b.ex_dest !== 4'h0 || b.ex_wb_en !== 1'b0 || b.ex_exe_cmd !== 4'h0) begin
            errors++; $display("FAIL reset_ex_fields: dest %h wb_en %b cmd %h want 0", b.ex_dest, b.ex_wb_en, b.ex_exe_cmd); end
        checks++; if (b.sel_src1 !== 2'b00 || b.sel_src2 !== 2'b00) begin
            errors++; $display("FAIL reset_sel: got %b/%b want 00/00", b.sel_src1, b.sel_src2); end
        checks++; if (fwd_count !== 16'h0) begin errors++; $display("FAIL reset_fwd_count: got %h want 0", fwd_count); end
        clear_inputs();
        b.id_valid = 1; b.id_val_rn = 32'h1234_5678; b.id_dest = 4'hA;
        rst = 1;
        #1;
        checks++; if (b.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_release_hold: got %0b want 0", b.ex_valid); end
        tick();
        checks++; if (b.ex_valid !== 1'b1 || b.ex_val_rn !== 32'h1234_5678 || b.ex_dest !== 4'hA) begin
            errors++; $display("FAIL reset_first_capture: valid %b rn %h dest %h want 1/12345678/a", b.ex_valid, b.ex_val_rn, b.ex_dest); end
    endtask

    task automatic test_capture();
        clear_inputs();
        b.id_valid = 1; b.id_src1 = 4'd3; b.id_val_rn = 32'hDEAD_BEEF; b.id_val_rm = 32'h0BAD_F00D;
        b.id_exe_cmd = 4'h9; b.id_mem_w_en = 1;
        tick();
        checks++; if (b.ex_val_rn !== 32'hDEAD_BEEF || b.ex_val_rm !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL capture_vals: rn %h rm %h want deadbeef/0badf00d", b.ex_val_rn, b.ex_val_rm); end
        checks++; if (b.ex_src1 !== 4'd3 || b.ex_exe_cmd !== 4'h9 || b.ex_mem_w_en !== 1'b1) begin
            errors++; $display("FAIL capture_ctrl: src1 %h cmd %h mw %b want 3/9/1", b.ex_src1, b.ex_exe_cmd, b.ex_mem_w_en); end
        checks++; if (b.sel_src1 !== 2'b00) begin errors++; $display("FAIL capture_sel: got %b want 00", b.sel_src1); end
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        b.id_valid = 1; b.id_src1 = 4'd5;
        tick();
        b.mem_dest = 4'd5; b.mem_wb_en = 1; b.wb_dest = 4'd5; b.wb_wb_en = 1;
        #1;
        checks++; if (b.sel_src1 !== 2'b01) begin errors++; $display("FAIL fwd_mem_over_wb: got %b want 01", b.sel_src1); end
        b.mem_wb_en = 0; #1;
        checks++; if (b.sel_src1 !== 2'b10) begin errors++; $display("FAIL fwd_wb: got %b want 10", b.sel_src1); end
        b.fwd_en = 0; #1;
        checks++; if (b.sel_src1 !== 2'b00) begin errors++; $display("FAIL fwd_disabled: got %b want 00", b.sel_src1); end
        b.fwd_en = 1; b.wb_wb_en = 0;
        b.id_src1 = 4'd15;
        tick();
        b.wb_dest = 4'd15; b.wb_wb_en = 1; #1;
        checks++; if (b.sel_src1 !== 2'b10) begin errors++; $display("FAIL fwd_pc_reg: got %b want 10", b.sel_src1); end
        b.wb_wb_en = 0;
    endtask

    task automatic test_two_src();
        clear_inputs();
        b.id_valid = 1; b.id_src1 = 4'd1; b.id_src2 = 4'd7; b.id_two_src = 0;
        tick();
        b.mem_dest = 4'd7; b.mem_wb_en = 1; #1;
        checks++; if (b.sel_src2 !== 2'b00 || b.sel_src1 !== 2'b00) begin
            errors++; $display("FAIL two_src_gated: got %b/%b want 00/00", b.sel_src1, b.sel_src2); end
        b.mem_wb_en = 0; b.id_two_src = 1;
        tick();
        b.mem_wb_en = 1; #1;
        checks++; if (b.sel_src2 !== 2'b01) begin errors++; $display("FAIL two_src_mem: got %b want 01", b.sel_src2); end
        b.mem_wb_en = 0; b.wb_dest = 4'd7; b.wb_wb_en = 1; #1;
        checks++; if (b.sel_src2 !== 2'b10) begin errors++; $display("FAIL two_src_wb: got %b want 10", b.sel_src2); end
        b.wb_wb_en = 0;
    endtask

    task automatic test_freeze_flush();
        clear_inputs();
        b.id_valid = 1; b.id_val_rn = 32'hA5A5_5A5A; b.id_dest = 4'd9; b.id_wb_en = 1;
        b.id_mem_r_en = 1; b.id_exe_cmd = 4'hC;
        tick();
        b.freeze = 1;
        for (int i = 0; i < 3; i++) begin
            b.id_val_rn = 32'h1111_0000 + i; b.id_dest = 4'(i); b.id_wb_en = 0; b.id_valid = 0;
            tick();
            checks++; if (b.ex_val_rn !== 32'hA5A5_5A5A || b.ex_dest !== 4'd9 || b.ex_valid !== 1'b1 || b.ex_exe_cmd !== 4'hC) begin
                errors++; $display("FAIL freeze_hold_%0d: rn %h dest %h valid %b cmd %h want a5a55a5a/9/1/c", i, b.ex_val_rn, b.ex_dest, b.ex_valid, b.ex_exe_cmd); end
        end
        b.id_valid = 1; b.id_wb_en = 1; b.flush = 1;
        tick();
        checks++; if (b.ex_valid !== 1'b0 || b.ex_wb_en !== 1'b0 || b.ex_mem_r_en !== 1'b0) begin
            errors++; $display("FAIL freeze_flush_ctrl: valid %b wb %b mr %b want 0/0/0", b.ex_valid, b.ex_wb_en, b.ex_mem_r_en); end
        checks++; if (b.ex_val_rn !== 32'h0 || b.ex_dest !== 4'h0 || b.ex_exe_cmd !== 4'h0) begin
            errors++; $display("FAIL freeze_flush_data: rn %h dest %h cmd %h want 0", b.ex_val_rn, b.ex_dest, b.ex_exe_cmd); end
        b.freeze = 0; b.flush = 0;
    endtask

    task automatic test_counter();
        clear_inputs();
        b.id_valid = 1; b.id_val_rn = 32'h77;
        tick();
        #2 rst = 0;
        #1;
        checks++; if (b.ex_valid !== 1'b0 || b.ex_val_rn !== 32'h0 || fwd_count !== 16'h0) begin
            errors++; $display("FAIL async_reset_mid_cycle: valid %b rn %h cnt %h want 0", b.ex_valid, b.ex_val_rn, fwd_count); end
        rst = 1;
        @(negedge clk);
        b.id_src1 = 4'd5;
        tick();
        b.mem_dest = 4'd5; b.mem_wb_en = 1; b.freeze = 1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (fwd_count !== 16'd0 || b.sel_src1 !== 2'b01) begin
            errors++; $display("FAIL counter_frozen: cnt %0d sel %b want 0/01", fwd_count, b.sel_src1); end
        b.freeze = 0; b.id_valid = 0;
        tick();
        checks++; if (fwd_count !== 16'd1) begin errors++; $display("FAIL counter_release: got %0d want 1", fwd_count); end
        b.flush = 1;
        tick();
        b.flush = 0;
        checks++; if (fwd_count !== 16'd1) begin errors++; $display("FAIL counter_after_flush: got %0d want 1", fwd_count); end
    endtask

    task automatic test_back_to_back();
        b.id_valid = 1; b.id_src1 = 4'd5; b.mem_dest = 4'd5; b.mem_wb_en = 1; b.fwd_en = 1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (fwd_count !== 16'd10) begin errors++; $display("FAIL back_to_back_count: got %0d want 10", fwd_count); end
        checks++; if (small_count !== 3'd7) begin errors++; $display("FAIL counter_saturate: got %0d want 7", small_count); end
        b.mem_wb_en = 0; b.id_valid = 0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_capture();
        test_fwd_priority();
        test_two_src();
        test_freeze_flush();
        test_counter();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
